serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first,
// with a single borrow flop. Start/busy/done handshake, one operation at a time.
//
// state | meaning
// IDLE  | waiting for ssStart, last result held on ssRes/ssBo
// RUN   | shifting one bit per cycle through the full-subtractor cell
// DONE  | result just published; ssDone high, a new start may be accepted
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             ssClk,
   input  logic             ssRstN,
   input  logic             ssStart,
   input  logic [WIDTH-1:0] ssOp1,
   input  logic [WIDTH-1:0] ssOp2,
   output logic             ssBusy,
   output logic             ssDone,
   output logic [WIDTH-1:0] ssRes,
   output logic             ssBo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic [CNT_W-1:0] bit_cnt;
   logic             borrow;

   logic accept;
   logic last_bit;
   logic d_bit;
   logic bout;

   assign accept   = ssStart && (state != RUN);
   assign last_bit = (bit_cnt == LAST_BIT);

   assign d_bit = a_sr[0] ^ b_sr[0] ^ borrow;
   assign bout  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);

   always_ff @(posedge ssClk or negedge ssRstN) begin
      if (!ssRstN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ssStart) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = ssStart ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ssClk or negedge ssRstN) begin
      if (!ssRstN) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         bit_cnt <= '0;
         borrow  <= 1'b0;
         ssRes   <= '0;
         ssBo    <= 1'b0;
      end else if (accept) begin
         a_sr    <= ssOp1;
         b_sr    <= ssOp2;
         diff_sr <= '0;
         bit_cnt <= '0;
         borrow  <= 1'b0;
      end else if (state == RUN) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
         bit_cnt <= bit_cnt + CNT_W'(1);
         borrow  <= bout;
         // Publish on the edge that consumes the MSB, so the final bit is included.
         if (last_bit) begin
            ssRes <= {d_bit, diff_sr[WIDTH-1:1]};
            ssBo  <= bout;
         end
      end
   end

   assign ssBusy = (state == RUN);
   assign ssDone = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: drivers push expected results,
// per-instance monitors pop and compare on every ssDone.
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] res;
      logic        bo;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   logic        start8 = 1'b0;
   logic [7:0]  op1_8 = '0, op2_8 = '0;
   logic        busy8, done8, bo8;
   logic [7:0]  res8;

   logic        start32 = 1'b0;
   logic [31:0] op1_32 = '0, op2_32 = '0;
   logic        busy32, done32, bo32;
   logic [31:0] res32;

   exp_t q8[$];
   exp_t q32[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .ssClk(clk), .ssRstN(rst_n), .ssStart(start8), .ssOp1(op1_8), .ssOp2(op2_8),
      .ssBusy(busy8), .ssDone(done8), .ssRes(res8), .ssBo(bo8)
   );

   serial_subtractor #(.WIDTH(32)) dut32 (
      .ssClk(clk), .ssRstN(rst_n), .ssStart(start32), .ssOp1(op1_32), .ssOp2(op2_32),
      .ssBusy(busy32), .ssDone(done32), .ssRes(res32), .ssBo(bo32)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: every ssDone must match the oldest outstanding expectation,
   // including the cycle it was due on.
   always @(negedge clk) begin
      if (done8) begin
         exp_t e;
         n_vec++;
         if (q8.size() == 0) begin
            n_err++;
            $display("FAIL done8_stray: got res=%0d bo=%0b at cycle %0d, expected no done", res8, bo8, cyc);
         end else begin
            e = q8.pop_front();
            if (res8 !== e.res[7:0] || bo8 !== e.bo || cyc != e.cyc) begin
               n_err++;
               $display("FAIL done8: got res=%0d bo=%0b cyc=%0d, expected res=%0d bo=%0b cyc=%0d",
                        res8, bo8, cyc, e.res[7:0], e.bo, e.cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done32) begin
         exp_t e;
         n_vec++;
         if (q32.size() == 0) begin
            n_err++;
            $display("FAIL done32_stray: got res=%0h bo=%0b at cycle %0d, expected no done", res32, bo32, cyc);
         end else begin
            e = q32.pop_front();
            if (res32 !== e.res || bo32 !== e.bo || cyc != e.cyc) begin
               n_err++;
               $display("FAIL done32: got res=%0h bo=%0b cyc=%0d, expected res=%0h bo=%0b cyc=%0d",
                        res32, bo32, cyc, e.res, e.bo, e.cyc);
            end
         end
      end
   end

   task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eres, input logic ebo);
      for (int i = 0; i < 100 && busy8; i++) @(negedge clk);
      if (busy8) chk("busy8_timeout", {31'd0, busy8}, 32'd0);
      start8 = 1'b1;
      op1_8  = a;
      op2_8  = b;
      q8.push_back('{res: {24'd0, eres}, bo: ebo, cyc: cyc + 1 + 8});
      @(negedge clk);
      start8 = 1'b0;
      op1_8  = 8'($urandom);
      op2_8  = 8'($urandom);
   endtask

   task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eres, input logic ebo);
      for (int i = 0; i < 100 && busy32; i++) @(negedge clk);
      if (busy32) chk("busy32_timeout", {31'd0, busy32}, 32'd0);
      start32 = 1'b1;
      op1_32  = a;
      op2_32  = b;
      q32.push_back('{res: eres, bo: ebo, cyc: cyc + 1 + 32});
      @(negedge clk);
      start32 = 1'b0;
      op1_32  = $urandom;
      op2_32  = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (q8.size() != 0 || q32.size() != 0); i++) @(negedge clk);
      chk("drain_q8", q8.size(), 0);
      chk("drain_q32", q32.size(), 0);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("rst_busy8", {31'd0, busy8}, 0);
      chk("rst_done8", {31'd0, done8}, 0);
      chk("rst_res8", {24'd0, res8}, 0);
      chk("rst_bo8", {31'd0, bo8}, 0);
      chk("rst_res32", res32, 0);
      rst_n = 1'b1;

      // basic: busy must be up right after the accepting edge
      issue8(8'd200, 8'd55, 8'd145, 1'b0);
      chk("basic_busy", {31'd0, busy8}, 1);
      drain();
      @(negedge clk);
      chk("basic_idle_done", {31'd0, done8}, 0);

      issue8(8'd55, 8'd200, 8'd111, 1'b1);
      issue8(8'd0, 8'd1, 8'd255, 1'b1);
      issue8(8'hA5, 8'hA5, 8'd0, 1'b0);
      drain();

      // start while busy is ignored
      issue8(8'd10, 8'd3, 8'd7, 1'b0);
      repeat (2) @(negedge clk);
      start8 = 1'b1; op1_8 = 8'd99; op2_8 = 8'd1;
      @(negedge clk);
      start8 = 1'b0; op1_8 = 8'd42; op2_8 = 8'd17;
      drain();
      repeat (3) @(negedge clk);
      chk("ignore_no_second_op", {31'd0, busy8}, 0);

      // back-to-back with operand switch on the DONE cycle
      k = cyc;
      start8 = 1'b1; op1_8 = 8'd100; op2_8 = 8'd1;
      q8.push_back('{res: 32'd99, bo: 1'b0, cyc: k + 9});
      repeat (9) @(negedge clk);
      chk("b2b_done_cycle", {31'd0, done8}, 1);
      op1_8 = 8'd5; op2_8 = 8'd6;
      q8.push_back('{res: 32'd255, bo: 1'b1, cyc: k + 18});
      @(negedge clk);
      start8 = 1'b0;
      drain();

      // reset mid-run
      issue8(8'd50, 8'd20, 8'd30, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy8}, 0);
      chk("midrst_done", {31'd0, done8}, 0);
      chk("midrst_res", {24'd0, res8}, 0);
      chk("midrst_bo", {31'd0, bo8}, 0);
      q8.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue8(8'd7, 8'd2, 8'd5, 1'b0);
      drain();

      issue32(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
      issue32(32'hDEAD_BEEF, 32'h1234_5678, 32'hCC79_6877, 1'b0);
      drain();

      fork
         for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            issue8(a, b, a - b, a < b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            issue32(a, b, a - b, a < b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
